// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: IDLE/ACCESS/DONE transaction FSM with address checking.
// Define DMEM_ARB_RR_EN for round-robin on simultaneous requests; otherwise port 0 wins.
module dmem_arbiter #(
   parameter int unsigned MEM_BYTES = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        p0_req,
   input  logic        p0_wr,
   input  logic [31:0] p0_addr,
   input  logic [31:0] p0_wdata,
   output logic        p0_ack,
   output logic        p0_err,
   output logic [31:0] p0_rdata,
   input  logic        p1_req,
   input  logic        p1_wr,
   input  logic [31:0] p1_addr,
   input  logic [31:0] p1_wdata,
   output logic        p1_ack,
   output logic        p1_err,
   output logic [31:0] p1_rdata,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam int unsigned AW = 32;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t          r_state;
   state_t          w_next;
   logic            w_latch;
   logic            w_finish;
   logic            w_sel;
   logic            w_sel_wr;
   logic [AW-1:0]   w_sel_addr;
   logic [AW-1:0]   w_sel_wdata;
   logic            w_rej;
   logic [AW-1:0]   w_load;

   logic            r_sel;
   logic            r_wr;
   logic            r_rej;
   logic [AW-1:0]   r_addr;
   logic [AW-1:0]   r_wdata;
   logic            r_rd_stb;
   logic            r_wr_stb;
   logic            r_ack0;
   logic            r_ack1;
   logic            r_err0;
   logic            r_err1;
   logic [AW-1:0]   r_rdata0;
   logic [AW-1:0]   r_rdata1;
`ifdef DMEM_ARB_RR_EN
   logic            r_last;
`endif

   // Port selection: a lone request always wins immediately.
   always_comb begin
`ifdef DMEM_ARB_RR_EN
      w_sel = p1_req & (~p0_req | ~r_last);
`else
      w_sel = p1_req & ~p0_req;
`endif
      w_sel_wr    = w_sel ? p1_wr    : p0_wr;
      w_sel_addr  = w_sel ? p1_addr  : p0_addr;
      w_sel_wdata = w_sel ? p1_wdata : p0_wdata;
      w_rej       = (w_sel_addr >= AW'(MEM_BYTES)) || (w_sel_addr[1:0] != 2'b00);
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      w_latch  = 1'b0;
      w_finish = 1'b0;
      case (r_state)
         IDLE: begin
            if (p0_req || p1_req) begin
               w_next  = ACCESS;
               w_latch = 1'b1;
            end
         end
         ACCESS: begin
            w_next   = DONE;
            w_finish = 1'b1;
         end
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   assign w_load = (r_wr || r_rej) ? '0 : mem_rdata;

   // Transaction latch, memory strobes and per-port response registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sel    <= 1'b0;
         r_wr     <= 1'b0;
         r_rej    <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_rd_stb <= 1'b0;
         r_wr_stb <= 1'b0;
         r_ack0   <= 1'b0;
         r_ack1   <= 1'b0;
         r_err0   <= 1'b0;
         r_err1   <= 1'b0;
         r_rdata0 <= '0;
         r_rdata1 <= '0;
`ifdef DMEM_ARB_RR_EN
         r_last   <= 1'b1;
`endif
      end else begin
         r_rd_stb <= w_latch & ~w_sel_wr & ~w_rej;
         r_wr_stb <= w_latch &  w_sel_wr & ~w_rej;
         r_ack0   <= 1'b0;
         r_ack1   <= 1'b0;
         if (w_latch) begin
            r_sel   <= w_sel;
            r_wr    <= w_sel_wr;
            r_rej   <= w_rej;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
`ifdef DMEM_ARB_RR_EN
            r_last  <= w_sel;
`endif
         end
         if (w_finish) begin
            if (r_sel) begin
               r_ack1   <= 1'b1;
               r_err1   <= r_rej;
               r_rdata1 <= w_load;
            end else begin
               r_ack0   <= 1'b1;
               r_err0   <= r_rej;
               r_rdata0 <= w_load;
            end
         end
      end
   end

   // Strobes are cut the moment reset rises so an aborted write never lands.
   assign mem_rd    = r_rd_stb & ~reset;
   assign mem_wr    = r_wr_stb & ~reset;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign p0_ack    = r_ack0;
   assign p1_ack    = r_ack1;
   assign p0_err    = r_err0;
   assign p1_err    = r_err1;
   assign p0_rdata  = r_rdata0;
   assign p1_rdata  = r_rdata1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus pushes expected responses, monitors pop and compare.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        p0_req, p0_wr, p1_req, p1_wr;
   logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
   logic        p0_ack, p0_err, p1_ack, p1_err;
   logic [31:0] p0_rdata, p1_rdata;
   logic        mem_rd, mem_wr;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
   } memx_t;

   exp_t  exp0_q[$];
   exp_t  exp1_q[$];
   memx_t memq[$];
   int    grant_q[$];
   int    n_checks = 0;
   int    n_pass   = 0;
   bit    mem_chk_en = 1'b1;
   bit    rec_grant  = 1'b0;
   logic [31:0] mem [0:255];

   always #5 clk = ~clk;

   dmem_arbiter #(.MEM_BYTES(1024)) dut (
      .clk(clk), .reset(reset),
      .p0_req(p0_req), .p0_wr(p0_wr), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
      .p1_req(p1_req), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   // Word-addressed memory model with combinational read.
   assign mem_rdata = mem[mem_addr[9:2]];
   always @(posedge clk) if (mem_wr) mem[mem_addr[9:2]] <= mem_wdata;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   task automatic drive(input int port, input bit req, input bit wr,
                        input logic [31:0] addr, input logic [31:0] wdata);
      if (port == 0) begin
         p0_req = req; p0_wr = wr; p0_addr = addr; p0_wdata = wdata;
      end else begin
         p1_req = req; p1_wr = wr; p1_addr = addr; p1_wdata = wdata;
      end
   endtask

   task automatic wait_ack(input int port, input bit chk_lat);
      int lat = 0;
      bit got = 1'b0;
      for (int i = 0; i < 60 && !got; i++) begin
         @(negedge clk);
         lat++;
         got = (port == 0) ? p0_ack : p1_ack;
      end
      if (!got) fail_now($sformatf("ack timeout port %0d", port));
      else if (chk_lat) check("ack latency", 32'(lat), 32'd3);
      @(posedge clk); #1;
      drive(port, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   // Issue one transaction; caller supplies the hand-computed response.
   task automatic txn(input int port, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input bit exp_err,
                      input logic [31:0] exp_rd, input bit chk_lat);
      exp_t e;
      e.err = exp_err; e.rdata = exp_rd;
      if (port == 0) exp0_q.push_back(e); else exp1_q.push_back(e);
      if (!exp_err) memq.push_back('{wr, addr, wdata});
      drive(port, 1'b1, wr, addr, wdata);
      wait_ack(port, chk_lat);
   endtask

   // Response monitor.
   always @(negedge clk) begin
      if (!reset) begin
         exp_t e;
         memx_t m;
         if (p0_ack && p1_ack) fail_now("both acks high");
         if (p0_ack) begin
            if (exp0_q.size() == 0) fail_now("unexpected p0_ack");
            else begin
               e = exp0_q.pop_front();
               check("p0_err", 32'(p0_err), 32'(e.err));
               check("p0_rdata", p0_rdata, e.rdata);
            end
            if (rec_grant) grant_q.push_back(0);
         end
         if (p1_ack) begin
            if (exp1_q.size() == 0) fail_now("unexpected p1_ack");
            else begin
               e = exp1_q.pop_front();
               check("p1_err", 32'(p1_err), 32'(e.err));
               check("p1_rdata", p1_rdata, e.rdata);
            end
            if (rec_grant) grant_q.push_back(1);
         end
         if (mem_chk_en && (mem_rd || mem_wr)) begin
            if (mem_rd && mem_wr) fail_now("both mem strobes high");
            else if (memq.size() == 0) fail_now("unexpected mem strobe");
            else begin
               m = memq.pop_front();
               check("mem_wr", 32'(mem_wr), 32'(m.wr));
               check("mem_addr", mem_addr, m.addr);
               if (m.wr) check("mem_wdata", mem_wdata, m.wdata);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_grant[8];
      exp_t e;
      reset = 1'b1;
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst p0_ack", 32'(p0_ack), 32'd0);
      check("rst p1_ack", 32'(p1_ack), 32'd0);
      check("rst p0_err", 32'(p0_err), 32'd0);
      check("rst p1_err", 32'(p1_err), 32'd0);
      check("rst p0_rdata", p0_rdata, 32'h0);
      check("rst p1_rdata", p1_rdata, 32'h0);
      check("rst mem strobes", {30'h0, mem_rd, mem_wr}, 32'h0);
      check("rst mem_addr", mem_addr, 32'h0);
      check("rst mem_wdata", mem_wdata, 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;

      // Write then read back through port 0.
      txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1);
      txn(0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1);

      // Port 1: valid read first so a rejected read visibly clears rdata.
      txn(1, 1'b1, 32'h14, 32'hA5A50001, 1'b0, 32'h0, 1'b1);
      txn(1, 1'b0, 32'h14, 32'h0, 1'b0, 32'hA5A50001, 1'b1);
      txn(1, 1'b0, 32'h400, 32'h0, 1'b1, 32'h0, 1'b1);
      txn(1, 1'b1, 32'h14, 32'hA5A50002, 1'b0, 32'h0, 1'b1);
      txn(1, 1'b0, 32'h14, 32'h0, 1'b0, 32'hA5A50002, 1'b1);
      txn(1, 1'b0, 32'h06, 32'h0, 1'b1, 32'h0, 1'b1);
      txn(0, 1'b1, 32'h401, 32'h77777777, 1'b1, 32'h0, 1'b1);
      txn(0, 1'b1, 32'h3FC, 32'hCAFE0001, 1'b0, 32'h0, 1'b0);
      txn(1, 1'b0, 32'h3FC, 32'h0, 1'b0, 32'hCAFE0001, 1'b0);

      // Address/data changes after latching must not reach memory.
      txn(0, 1'b1, 32'h34, 32'h34343434, 1'b0, 32'h0, 1'b0);
      e.err = 1'b0; e.rdata = 32'h0;
      exp0_q.push_back(e);
      memq.push_back('{1'b1, 32'h30, 32'h35353535});
      drive(0, 1'b1, 1'b1, 32'h30, 32'h35353535);
      @(posedge clk); #1;
      drive(0, 1'b1, 1'b1, 32'h34, 32'h99999999);
      wait_ack(0, 1'b0);
      txn(0, 1'b0, 32'h30, 32'h0, 1'b0, 32'h35353535, 1'b1);
      txn(0, 1'b0, 32'h34, 32'h0, 1'b0, 32'h34343434, 1'b1);

      // Reset during ACCESS of a write aborts it.
      txn(0, 1'b1, 32'h20, 32'h11111111, 1'b0, 32'h0, 1'b0);
      mem_chk_en = 1'b0;
      drive(0, 1'b1, 1'b1, 32'h20, 32'h22222222);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      mem_chk_en = 1'b1;
      repeat (3) @(negedge clk);
      check("abort p0_rdata", p0_rdata, 32'h0);
      check("abort mem[0x20]", mem[8], 32'h11111111);
      @(posedge clk); #1;
      txn(0, 1'b0, 32'h20, 32'h0, 1'b0, 32'h11111111, 1'b1);

      // Simultaneous requests from a fresh reset.
      reset = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      mem_chk_en = 1'b0;
      rec_grant  = 1'b1;
      fork
         begin
            for (int i = 0; i < 4; i++)
               txn(0, 1'b1, 32'h40 + 32'(4 * i), 32'hA0000000 + 32'(i), 1'b0, 32'h0, 1'b0);
         end
         begin
            for (int j = 0; j < 4; j++)
               txn(1, 1'b1, 32'h80 + 32'(4 * j), 32'hB0000000 + 32'(j), 1'b0, 32'h0, 1'b0);
         end
      join
      rec_grant = 1'b0;
      memq.delete();
      mem_chk_en = 1'b1;
`ifdef DMEM_ARB_RR_EN
      exp_grant = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
      exp_grant = '{0, 0, 0, 0, 1, 1, 1, 1};
`endif
      check("grant count", 32'(grant_q.size()), 32'd8);
      for (int k = 0; k < 8; k++) begin
         if (k < grant_q.size())
            check($sformatf("grant[%0d]", k), 32'(grant_q[k]), 32'(exp_grant[k]));
      end
      txn(0, 1'b0, 32'h4C, 32'h0, 1'b0, 32'hA0000003, 1'b1);
      txn(1, 1'b0, 32'h80, 32'h0, 1'b0, 32'hB0000000, 1'b1);

      repeat (4) @(negedge clk);
      check("exp0 queue drained", 32'(exp0_q.size()), 32'd0);
      check("exp1 queue drained", 32'(exp1_q.size()), 32'd0);
      check("mem queue drained", 32'(memq.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
